// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter
//
// Loadable up/down counter with wrap-around reporting and sticky
// overflow/underflow status. All outputs come straight from flops.
//
// Build option:
//   UPDOWN_COUNTER_SAT_EN  defined   -> saturating count (hold at max/0)
//                          undefined -> modulo 2^WIDTH wrap-around (default)
//
// Ports:
//   clk       in   1      sole clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   load      in   1      synchronous parallel load of data (beats counting)
//   updown    in   1      direction: 1 = up, 0 = down
//   data      in   WIDTH  load value
//   data_out  out  WIDTH  registered count
//   wrap      out  1      one-cycle pulse: previous edge hit a boundary
//   ovf       out  1      sticky: up-count attempted from max
//   unf       out  1      sticky: down-count attempted from 0
// ---------------------------------------------------------------------------
module updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             rst_sync_q;
    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d,  wrap_q;
    logic             ovf_d,   ovf_q;
    logic             unf_d,   unf_q;

    // Reset asserts asynchronously but releases on a clock edge: the edge
    // after rst falls only clears this flop, so the first real update
    // happens on the following edge with no partial state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 1'b1;
        end else begin
            rst_sync_q <= 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (rst_sync_q) begin
            count_d = CNT_ZERO;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            // Load wins over any boundary on the same edge.
            count_d = data;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (updown) begin
            if (count_q == CNT_MAX) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                count_d = CNT_MAX;
`else
                count_d = CNT_ZERO;
`endif
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            if (count_q == CNT_ZERO) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                count_d = CNT_ZERO;
`else
                count_d = CNT_MAX;
`endif
                wrap_d = 1'b1;
                unf_d  = 1'b1;
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_ZERO;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_out = count_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter
//
// Directed, table-driven bench for updown_counter (WIDTH = 4). Expected
// values for boundary rows follow the build option UPDOWN_COUNTER_SAT_EN.
// ---------------------------------------------------------------------------
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       load;
    logic       updown;
    logic [3:0] data;
    logic [3:0] data_out;
    logic       wrap;
    logic       ovf;
    logic       unf;

    int checks;
    int failures;

    typedef struct {
        logic       load;
        logic       updown;
        logic [3:0] data;
        logic [3:0] exp_dout;
        logic       exp_wrap;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[$];

    updown_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .updown   (updown),
        .data     (data),
        .data_out (data_out),
        .wrap     (wrap),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_all(input string name, input logic [3:0] e_dout,
                             input logic e_wrap, input logic e_ovf,
                             input logic e_unf);
        checks++;
        if (data_out !== e_dout || wrap !== e_wrap || ovf !== e_ovf ||
            unf !== e_unf) begin
            failures++;
            $display("FAIL %s: got dout=%h wrap=%b ovf=%b unf=%b, want dout=%h wrap=%b ovf=%b unf=%b",
                     name, data_out, wrap, ovf, unf, e_dout, e_wrap, e_ovf, e_unf);
        end
    endtask

    task automatic step(input logic l, input logic ud, input logic [3:0] d);
        @(negedge clk);
        load   = l;
        updown = ud;
        data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic l, input logic ud, input logic [3:0] d,
                       input logic [3:0] e, input logic w, input logic o,
                       input logic u);
        vec_t v;
        v.load = l; v.updown = ud; v.data = d;
        v.exp_dout = e; v.exp_wrap = w; v.exp_ovf = o; v.exp_unf = u;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        load     = 1'b0;
        updown   = 1'b1;
        data     = 4'h0;

        //       load up data  dout                 wrap       ovf   unf
        add(1'b1, 1'b0, 4'hA, 4'hA,                1'b0,      1'b0, 1'b0);
        add(1'b1, 1'b1, 4'hE, 4'hE,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, 4'hF,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h0,   1'b1,      1'b1, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h1,   SAT,       1'b1, 1'b0);
        add(1'b1, 1'b0, 4'h1, 4'h1,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 4'h0, 4'h0,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF,   1'b1,      1'b0, 1'b1);
        add(1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hE,   SAT,       1'b0, 1'b1);
        add(1'b1, 1'b0, 4'hF, 4'hF,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h0,   1'b1,      1'b1, 1'b0);
        add(1'b0, 1'b0, 4'h0, SAT ? 4'hE : 4'hF,   !SAT,      1'b1, !SAT);
        add(1'b1, 1'b1, 4'h3, 4'h3,                1'b0,      1'b0, 1'b0);
        add(1'b1, 1'b0, 4'h5, 4'h5,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, 4'h6,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, 4'h7,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 4'h0, 4'h6,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, 4'h7,                1'b0,      1'b0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h0,   1'b1,      1'b1, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h1,   SAT,       1'b1, 1'b0);
        add(1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h2,   SAT,       1'b1, 1'b0);
        add(1'b1, 1'b0, 4'h0, 4'h0,                1'b0,      1'b0, 1'b0);
        add(1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF,   1'b1,      1'b0, 1'b1);
        add(1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hE,   SAT,       1'b0, 1'b1);

        // Power-on reset, then the release edge which must not update.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        updown = 1'b1;
        @(posedge clk);
        #1;
        check_all("release_edge", 4'h0, 1'b0, 1'b0, 1'b0);

        // Count to 9, then reset asynchronously between edges.
        step(1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b1, 4'h0);
        check_all("pre_reset_9", 4'h9, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("release_edge2", 4'h0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].updown, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].exp_dout,
                      vecs[i].exp_wrap, vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Reset mid-count with sticky flags set clears everything.
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset_flags", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Loadable up/down counter that sits on the DUT side of the counter interface the write BFM drives and the write/read monitors sample. It consumes `load`, `updown` and `data`, and produces the registered count on `data_out`. It also reports wrap-around events and sticky overflow/underflow status for scoreboard cross-checking.

## Interface
- `WIDTH`, default 4: counter and data width in bits.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; one clock, reset asynchronous active-high.
- `load`  input  1  synchronous parallel load of `data`.
- `updown`  input  1  count direction: 1 = up, 0 = down.
- `data`  input  WIDTH  load value.
- `data_out`  output  WIDTH  registered count value.
- `wrap`  output  1  registered one-cycle pulse marking a wrap-around or saturation hit on the previous edge.
- `ovf`  output  1  sticky: an up-count was attempted from max (2^WIDTH-1).
- `unf`  output  1  sticky: a down-count was attempted from 0.

## Operation
- There is no enable. The counter acts on every rising `clk` edge while `rst` is low.
- Priority per edge: `rst` first, then `load`, then count.
- Reset (async assert, any time, including mid-count): `data_out`=0, `wrap`=0, `ovf`=0, `unf`=0. The first count edge follows the first edge after `rst` deasserts.
- Load: `data_out` <= `data`; `wrap` <= 0; `ovf` and `unf` are cleared. `updown` is ignored on this edge.
- Count up (`load`=0, `updown`=1):
  - `data_out` <= `data_out`+1, modulo 2^WIDTH.
  - From max: `data_out` <= 0, `wrap` <= 1, `ovf` <= 1.
- Count down (`load`=0, `updown`=0):
  - `data_out` <= `data_out`-1, modulo 2^WIDTH.
  - From 0: `data_out` <= max, `wrap` <= 1, `unf` <= 1.
- `wrap` is 0 on every edge that does not hit a boundary.
- `ovf` and `unf` stay set until the next `load` or `rst`. Both may be set at the same time.
- Load coinciding with a boundary: the load wins. No wrap pulse, and the flags are cleared.
- Changing `updown` takes effect on the same edge. There is no extra latency or dead cycle.

## Timing
- Inputs are sampled at posedge k. `data_out`, `wrap`, `ovf` and `unf` update just after posedge k.
- A read monitor sampling at posedge k+1 sees the result of edge k. Latency is one clock.
- All outputs are driven directly from flops. There are no combinational input-to-output paths.
- Inputs must be stable around the edge. The BFM drives them through its clocking block, so they change after the edge.
- Reset deassertion is synchronised to `clk`. Release takes effect on a clean edge, with no partial update.

## Configuration
- Macro: `UPDOWN_COUNTER_SAT_EN`.
- Undefined (default): wrap-around counting, as described above.
- Defined: saturating counting.
  - Counting up at max holds max. `ovf` <= 1 and `wrap` <= 1 (saturation hit).
  - Counting down at 0 holds 0. `unf` <= 1 and `wrap` <= 1.
  - `wrap` pulses on every edge that is held at a boundary.
  - Load and reset behaviour are unchanged.

## Test plan
- Reset and load: assert `rst` mid-count at `data_out`=9 → all outputs are 0 immediately, without waiting for an edge. Then release, `load`=1, `data`=4'hA → `data_out`=A one edge later; flags 0.
- Up wrap: load E, then `updown`=1 for 3 edges → `data_out` sequence F, 0, 1. `wrap`=1 only in the cycle showing 0. `ovf` stays 1; `unf`=0.
- Down wrap: load 1, then `updown`=0 for 3 edges → `data_out` sequence 0, F, E. `wrap` pulses with F. `unf`=1 and stays 1.
- Load vs boundary: at `data_out`=F with `updown`=1, `load`=1, `data`=3 → `data_out`=3, `wrap`=0. `ovf` is cleared even if previously set.
- Direction flip: from 5, pattern up, up, down, up → 6, 7, 6, 7, each with one-cycle latency and no wrap.
- With `UPDOWN_COUNTER_SAT_EN` defined: load F, count up 3 edges → `data_out` stays F, `wrap`=1 for each edge, `ovf`=1. Load 0, count down 2 edges → stays 0, `unf`=1.
